// File: rtl/brent_kung_adder16_pkg.sv
// Shared constants and a behavioural reference sum for the 16-bit Brent-Kung adder.
package brent_kung_adder16_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int LOG2W     = $clog2(DEF_WIDTH);

  // Plain-arithmetic {Cout,SUM} for the default width.
  function automatic logic [DEF_WIDTH:0] bk_ref(input logic [DEF_WIDTH-1:0] x,
                                                input logic [DEF_WIDTH-1:0] y,
                                                input logic                 cin);
    return {1'b0, x} + {1'b0, y} + {{DEF_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// Black prefix cell: (go,po) = (gi | pi&gj, pi&pj). Used as a gray cell when po is ignored.
module bk_gp_cell (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);

  assign go = gi | (pi & gj);
  assign po = pi & pj;

endmodule

// File: rtl/brent_kung_adder16.sv
// Brent-Kung parallel-prefix adder with carry-in folded into bit 0 and a registered result.
module brent_kung_adder16
  import brent_kung_adder16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic             Cout,
  output logic [WIDTH-1:0] SUM
);

  localparam int L = $clog2(WIDTH);

  logic [WIDTH-1:0]        g0, p0;
  logic [L:0][WIDTH-1:0]   g_up, p_up;
  logic [L-1:0][WIDTH-1:0] g_dn, p_dn;
  logic [WIDTH-1:0]        carry;
  logic [WIDTH-1:0]        sum_d, sum_q;
  logic                    cout_d, cout_q;
  logic                    unused_p;

  assign g0 = X & Y;
  assign p0 = X ^ Y;

  assign g_up[0] = {g0[WIDTH-1:1], g0[0] | (p0[0] & Cin)};
  assign p_up[0] = p0;

  // Up-sweep: at level k, nodes with (i+1) a multiple of 2^k absorb the span below them.
  for (genvar k = 1; k <= L; k++) begin : g_up_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_up_bit
      if (((i + 1) % (1 << k)) == 0) begin : g_cell
        bk_gp_cell u_cell (
          .gi(g_up[k-1][i]),
          .pi(p_up[k-1][i]),
          .gj(g_up[k-1][i-(1<<(k-1))]),
          .pj(p_up[k-1][i-(1<<(k-1))]),
          .go(g_up[k][i]),
          .po(p_up[k][i])
        );
      end else begin : g_pass
        assign g_up[k][i] = g_up[k-1][i];
        assign p_up[k][i] = p_up[k-1][i];
      end
    end
  end

  assign g_dn[0] = g_up[L];
  assign p_dn[0] = p_up[L];

  // Down-sweep: fill the mid-span prefixes from the completed power-of-two prefixes.
  for (genvar j = 1; j < L; j++) begin : g_dn_lvl
    localparam int H = 1 << (L - j - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_dn_bit
      if ((((i + 1) % (2 * H)) == H) && ((i + 1) >= 3 * H)) begin : g_cell
        bk_gp_cell u_cell (
          .gi(g_dn[j-1][i]),
          .pi(p_dn[j-1][i]),
          .gj(g_dn[j-1][i-H]),
          .pj(p_dn[j-1][i-H]),
          .go(g_dn[j][i]),
          .po(p_dn[j][i])
        );
      end else begin : g_pass
        assign g_dn[j][i] = g_dn[j-1][i];
        assign p_dn[j][i] = p_dn[j-1][i];
      end
    end
  end

  assign unused_p = ^p_dn[L-1];

  assign carry  = {g_dn[L-1][WIDTH-2:0], Cin};
  assign sum_d  = p0 ^ carry;
  assign cout_d = g_dn[L-1][WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign SUM  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_brent_kung_adder16.sv
// Self-checking bench: directed vectors, reset behaviour and a random regression.
module tb_brent_kung_adder16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] X, Y;
  logic        Cin;
  logic        Cout;
  logic [15:0] SUM;

  int total = 0;
  int bad   = 0;

  brent_kung_adder16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .X    (X),
    .Y    (Y),
    .Cin  (Cin),
    .Cout (Cout),
    .SUM  (SUM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[16:0];
  endfunction

  // Drive one vector, clock it in, and check the result one edge later.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [16:0] exp_v);
    X = a; Y = b; Cin = c;
    @(posedge clk); #1;
    chk(tag, {Cout, SUM}, exp_v);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;

    rst_n = 1'b0; X = 16'd20; Y = 16'd87; Cin = 1'b1;
    #1 chk("reset_async", {Cout, SUM}, 17'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_hold", {Cout, SUM}, 17'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", {Cout, SUM}, 17'd108);

    step("b2b_642",   16'd280,   16'd361,  1'b1, 17'd642);
    step("b2b_7001",  16'd2000,  16'd5000, 1'b1, 17'd7001);
    step("b2b_27400", 16'd6400,  16'd21000,1'b0, 17'd27400);
    step("b2b_1111",  16'd750,   16'd361,  1'b0, 17'd1111);
    step("b2b_29801", 16'd25000, 16'd4801, 1'b0, 17'd29801);
    step("b2b_8951",  16'd3150,  16'd5800, 1'b1, 17'd8951);
    step("b2b_14",    16'd7,     16'd6,    1'b1, 17'd14);

    step("ripple_ffff_0",    16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    step("ripple_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    step("ripple_msb",       16'h8000, 16'h8000, 1'b0, 17'h10000);
    step("cin_00ff",         16'h00FF, 16'h0000, 1'b1, 17'h00100);
    step("zero",             16'h0000, 16'h0000, 1'b0, 17'h00000);
    step("preload",          16'h1234, 16'h1111, 1'b0, 17'h02345);

    // Reset lands between edges while 0x7FFF+1 waits at the inputs.
    X = 16'h7FFF; Y = 16'h0001; Cin = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midreset_clear", {Cout, SUM}, 17'd0);
    @(posedge clk); #1;
    chk("midreset_hold", {Cout, SUM}, 17'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("midreset_release_pre", {Cout, SUM}, 17'd0);
    @(posedge clk); #1;
    chk("midreset_release", {Cout, SUM}, 17'h08000);

    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      step("random", ra, rb, rc, model(ra, rb, rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
